// File: rtl/cache_ctrl_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ctrl_param_pkg                                            |
// | Brief    : State encodings shared by the cache controller and its bench.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cache_ctrl_param_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_state_w-1:0] c_st_cmp_rd = 3'd1;
    localparam logic [c_state_w-1:0] c_st_cmp_wr = 3'd2;
    localparam logic [c_state_w-1:0] c_st_wb     = 3'd3;
    localparam logic [c_state_w-1:0] c_st_fill   = 3'd4;
    localparam logic [c_state_w-1:0] c_st_merge  = 3'd5;
    localparam logic [c_state_w-1:0] c_st_done   = 3'd6;
    localparam logic [c_state_w-1:0] c_st_error  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_param_mem_rd_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_rd_tracker                                                  |
// | Brief    : Valid shift register marking when an accepted read returns.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_rd_tracker #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    output logic o_pop
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_push;
                end
            end
        end else begin : g_shift
            // A push lands at the tail and pops out DEPTH cycles later.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {i_push, r_sr[DEPTH-1:1]};
                end
            end
        end
    endgenerate

    assign o_pop = r_sr[0];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ctrl_param                                                |
// | Brief    : Direct-mapped write-back/write-allocate cache controller FSM.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cache_ctrl_param
    import cache_ctrl_param_pkg::*;
#(
    parameter  int ADDR_W   = 16,
    parameter  int DATA_W   = 16,
    parameter  int TAG_W    = 5,
    parameter  int INDEX_W  = 8,
    parameter  int WORDS    = 4,
    parameter  int MEM_LAT  = 4,
    localparam int OFFSET_W = ADDR_W - TAG_W - INDEX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Rd,
    input  logic                Wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_input,
    input  logic                hit,
    input  logic                valid,
    input  logic                dirty,
    input  logic [TAG_W-1:0]    tag_out,
    input  logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_out_m,
    input  logic                mem_stall,
    output logic                enable,
    output logic                comp,
    output logic                write_c,
    output logic                valid_in,
    output logic [INDEX_W-1:0]  index,
    output logic [OFFSET_W-1:0] offset,
    output logic [TAG_W-1:0]    tag_in,
    output logic [DATA_W-1:0]   data_in,
    output logic                rd_m,
    output logic                wr_m,
    output logic [TAG_W-1:0]    tag_m,
    output logic [OFFSET_W-1:0] offset_m,
    output logic [DATA_W-1:0]   data_in_m,
    output logic                done,
    output logic                cache_hit,
    output logic                stall,
    output logic                errCtrl
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int BYTE_W = OFFSET_W - WSEL_W;

    localparam logic [WSEL_W-1:0] c_last  = WSEL_W'(WORDS - 1);
    localparam logic [WSEL_W:0]   c_words = (WSEL_W + 1)'(WORDS);

    logic [c_state_w-1:0] r_state;
    logic [WSEL_W:0]      r_cnt;     // write-back beat, then fill issue count
    logic [WSEL_W-1:0]    r_ret;     // fill return count
    logic                 r_wr;      // request was a write: merge after fill

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [OFFSET_W-1:0]  w_addr_off;
    logic [OFFSET_W-1:0]  w_cnt_off;
    logic [OFFSET_W-1:0]  w_ret_off;
    logic                 w_issue_pending;
    logic                 w_push;
    logic                 w_pop;

    assign w_tag      = addr[ADDR_W-1 -: TAG_W];
    assign w_index    = addr[ADDR_W-TAG_W-1 -: INDEX_W];
    assign w_addr_off = addr[OFFSET_W-1:0];
    assign w_cnt_off  = OFFSET_W'(r_cnt[WSEL_W-1:0]) << BYTE_W;
    assign w_ret_off  = OFFSET_W'(r_ret) << BYTE_W;

    assign w_issue_pending = (r_cnt < c_words);
    assign w_push          = (r_state == c_st_fill) && w_issue_pending && !mem_stall;

    mem_rd_tracker #(
        .DEPTH (MEM_LAT)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .o_pop  (w_pop)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ret   <= '0;
            r_wr    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_wr <= Wr;
                    if (Rd && Wr) begin
                        r_state <= c_st_error;
                    end else if (Rd) begin
                        r_state <= c_st_cmp_rd;
                    end else if (Wr) begin
                        r_state <= c_st_cmp_wr;
                    end
                end
                c_st_cmp_rd, c_st_cmp_wr: begin
                    r_cnt <= '0;
                    r_ret <= '0;
                    if (hit && valid) begin
                        r_state <= c_st_idle;
                    end else if (valid && dirty) begin
                        r_state <= c_st_wb;
                    end else begin
                        r_state <= c_st_fill;
                    end
                end
                c_st_wb: begin
                    if (!mem_stall) begin
                        if (r_cnt[WSEL_W-1:0] == c_last) begin
                            r_cnt   <= '0;
                            r_state <= c_st_fill;
                        end else begin
                            r_cnt <= r_cnt + (WSEL_W + 1)'(1);
                        end
                    end
                end
                c_st_fill: begin
                    // Issue and return are independent and may both fire.
                    if (w_push) begin
                        r_cnt <= r_cnt + (WSEL_W + 1)'(1);
                    end
                    if (w_pop) begin
                        r_ret <= r_ret + WSEL_W'(1);
                        if (r_ret == c_last) begin
                            r_state <= r_wr ? c_st_merge : c_st_done;
                        end
                    end
                end
                c_st_merge: r_state <= c_st_done;
                c_st_done:  r_state <= c_st_idle;
                c_st_error: r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        enable    = 1'b0;
        comp      = 1'b0;
        write_c   = 1'b0;
        valid_in  = 1'b0;
        index     = w_index;
        offset    = w_addr_off;
        tag_in    = w_tag;
        data_in   = data_input;
        rd_m      = 1'b0;
        wr_m      = 1'b0;
        tag_m     = w_tag;
        offset_m  = w_addr_off;
        data_in_m = data_out;
        done      = 1'b0;
        cache_hit = 1'b0;
        stall     = 1'b1;
        errCtrl   = 1'b0;
        case (r_state)
            c_st_idle: begin
                enable = 1'b1;
                stall  = 1'b0;
            end
            c_st_cmp_rd, c_st_cmp_wr: begin
                enable  = 1'b1;
                comp    = 1'b1;
                write_c = (r_state == c_st_cmp_wr);
                if (hit && valid) begin
                    done      = 1'b1;
                    cache_hit = 1'b1;
                end
            end
            c_st_wb: begin
                enable   = 1'b1;
                wr_m     = 1'b1;
                offset   = w_cnt_off;
                offset_m = w_cnt_off;
                tag_m    = tag_out;
            end
            c_st_fill: begin
                rd_m     = w_issue_pending;
                offset_m = w_cnt_off;
                offset   = w_ret_off;
                if (w_pop) begin
                    enable   = 1'b1;
                    write_c  = 1'b1;
                    valid_in = 1'b1;
                    data_in  = data_out_m;
                end
            end
            c_st_merge: begin
                enable   = 1'b1;
                comp     = 1'b1;
                write_c  = 1'b1;
                valid_in = 1'b1;
            end
            c_st_done: begin
                enable = 1'b1;
                done   = 1'b1;
            end
            c_st_error: begin
                errCtrl = 1'b1;
                done    = 1'b1;
            end
            default: errCtrl = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
